// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller. This file has no ports.
// It holds:
//   - the EX operand-source encodings,
//   - the hard-wired zero register,
//   - the stage-entry structs,
//   - the forwarding-select helper.
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [1:0]       FWD_RF    = 2'b00;
    localparam logic [1:0]       FWD_EXMEM = 2'b01;
    localparam logic [1:0]       FWD_MEMWB = 2'b10;
    localparam logic [REG_W-1:0] REG_ZERO  = '0;

    // Tracking state that every stage keeps for its instruction.
    typedef struct packed {
        logic             valid;
        logic             we;
        logic             mem_read;
        logic [REG_W-1:0] dst;
    } entry_t;

    // EX additionally remembers its source registers for operand forwarding.
    typedef struct packed {
        entry_t           ent;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } ex_entry_t;

    // True when a stage entry will write a real register that matches src.
    function automatic logic writes_reg(input entry_t e, input logic [REG_W-1:0] src);
        return e.valid && e.we && (e.dst != REG_ZERO) && (e.dst == src);
    endfunction

    // The younger producer (MEM) wins over the older one (WB).
    function automatic logic [1:0] fwd_sel(input entry_t mem, input entry_t wb,
                                           input logic [REG_W-1:0] src);
        if (writes_reg(mem, src))
            return FWD_EXMEM;
        else if (writes_reg(wb, src))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mux5bit.sv
// -----------------------------------------------------------------------------
// mux5bit
// Two-way selector for a 5-bit register specifier.
// Ports:
//   sel : 0 selects a, 1 selects b
//   a   : 5-bit input
//   b   : 5-bit input
//   y   : selected 5-bit value
// -----------------------------------------------------------------------------
module mux5bit (
    input  logic       sel,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Tracks the EX/MEM/WB destinations of a 5-stage pipeline. From them it
// produces:
//   - the load-use stall,
//   - the branch flush,
//   - the EX operand forwarding selects,
//   - a saturating count of stall cycles.
//
// Ports:
//   clk                    : clock; all state updates on the rising edge
//   rst_n                  : synchronous reset, active-low
//   id_valid               : decode holds a real instruction
//   id_rs, id_rt, id_rd    : decode register fields
//   id_use_rs, id_use_rt   : the decode instruction reads that operand
//   id_reg_dst             : destination select (0 = rt, 1 = rd)
//   id_reg_write           : the decode instruction writes the register file
//   id_mem_read            : the decode instruction is a load
//   branch_taken           : redirect; squashes decode
//   stall                  : hold PC and IF/ID
//   flush_id               : zero IF/ID
//   fwd_a, fwd_b           : EX operand source (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   ex_dst, mem_dst, wb_dst: tracked destinations, 0 when the stage is empty
//   wb_we                  : register-file write enable
//   stall_cnt              : saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush_id,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] ex_dst,
    output logic [REG_W-1:0] mem_dst,
    output logic [REG_W-1:0] wb_dst,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [REG_W-1:0] sel_dst;
    logic [REG_W-1:0] id_dst;
    logic             load_use;
    logic             stall_int;
    ex_entry_t        ex_next;

    ex_entry_t        ent_p0;    // EX
    entry_t           ent_p1;    // MEM
    entry_t           ent_p2;    // WB
    logic [CNT_W-1:0] cnt_q;

    // Saturating increment for the stall counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    mux5bit u_dst_mux (
        .sel (id_reg_dst),
        .a   (id_rt),
        .b   (id_rd),
        .y   (sel_dst)
    );

    // A non-writing instruction carries register 0 so it can never match.
    assign id_dst = id_reg_write ? sel_dst : REG_ZERO;

    // Decode stage: hazard detection and next EX entry
    always_comb begin
        load_use = id_valid && ent_p0.ent.valid && ent_p0.ent.mem_read &&
                   (ent_p0.ent.dst != REG_ZERO) &&
                   ((id_use_rs && (id_rs == ent_p0.ent.dst)) ||
                    (id_use_rt && (id_rt == ent_p0.ent.dst)));

        // A taken branch squashes decode, so the hazard it would have caused is moot.
        stall_int = load_use && !branch_taken;

        ex_next = '0;
        if (id_valid && !load_use && !branch_taken) begin
            ex_next.ent.valid    = 1'b1;
            ex_next.ent.we       = id_reg_write;
            ex_next.ent.mem_read = id_mem_read;
            ex_next.ent.dst      = id_dst;
            ex_next.rs           = id_rs;
            ex_next.rt           = id_rt;
        end
    end

    // EX / MEM / WB stage registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_p0 <= '0;
            ent_p1 <= '0;
            ent_p2 <= '0;
            cnt_q  <= '0;
        end else begin
            ent_p0 <= ex_next;
            ent_p1 <= ent_p0.ent;
            ent_p2 <= ent_p1;
            if (stall_int)
                cnt_q <= sat_inc(cnt_q);
        end
    end

    // Outputs: quiet while reset is held, even before the clearing edge.
    always_comb begin
        stall    = 1'b0;
        flush_id = 1'b0;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        ex_dst   = REG_ZERO;
        mem_dst  = REG_ZERO;
        wb_dst   = REG_ZERO;
        wb_we    = 1'b0;
        if (rst_n) begin
            stall    = stall_int;
            flush_id = branch_taken;
            fwd_a    = fwd_sel(ent_p1, ent_p2, ent_p0.rs);
            fwd_b    = fwd_sel(ent_p1, ent_p2, ent_p0.rt);
            ex_dst   = ent_p0.ent.valid ? ent_p0.ent.dst : REG_ZERO;
            mem_dst  = ent_p1.valid     ? ent_p1.dst     : REG_ZERO;
            wb_dst   = ent_p2.valid     ? ent_p2.dst     : REG_ZERO;
            wb_we    = ent_p2.valid && ent_p2.we;
        end
    end

    assign stall_cnt = cnt_q;

    // Past EX, the load flag has no consumer.
    logic unused_mem_read;
    assign unused_mem_read = ent_p1.mem_read ^ ent_p2.mem_read;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl.
// The driver applies one decode instruction per cycle and queues the
// hand-computed output vector for that cycle. A monitor pops the queue on each
// falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_use_rs, id_use_rt, id_reg_dst, id_reg_write, id_mem_read;
    logic        branch_taken;
    logic        stall, flush_id, wb_we;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_reg_dst   (id_reg_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush_id     (flush_id),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .ex_dst       (ex_dst),
        .mem_dst      (mem_dst),
        .wb_dst       (wb_dst),
        .wb_we        (wb_we),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        string       nm;
        logic [37:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // {stall, flush, fwd_a, fwd_b, ex_dst, mem_dst, wb_dst, wb_we, stall_cnt}
    function automatic logic [37:0] outs();
        return {stall, flush_id, fwd_a, fwd_b, ex_dst, mem_dst, wb_dst, wb_we, stall_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic v, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic rdst,
                       input logic rw, input logic mr, input logic br);
        rst_n        = r;
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_reg_dst   = rdst;
        id_reg_write = rw;
        id_mem_read  = mr;
        branch_taken = br;
    endtask

    task automatic nop();
        drv(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add(input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic br);
        drv(1'b1, 1'b1, s, t, d, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, br);
    endtask

    task automatic lw(input logic [4:0] t, input logic [4:0] s);
        drv(1'b1, 1'b1, s, t, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic expect_out(input string nm, input logic st, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [4:0] ed, input logic [4:0] md,
                              input logic [4:0] wd, input logic we,
                              input logic [15:0] cnt);
        exp_t e;
        e.nm = nm;
        e.v  = {st, fl, fa, fb, ed, md, wd, we, cnt};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (outs() !== e.v) begin
                errors++;
                $display("FAIL %s got st=%b fl=%b fa=%b fb=%b ex=%0d mem=%0d wb=%0d we=%b cnt=%0d exp st=%b fl=%b fa=%b fb=%b ex=%0d mem=%0d wb=%0d we=%b cnt=%0d",
                         e.nm, stall, flush_id, fwd_a, fwd_b, ex_dst, mem_dst, wb_dst, wb_we, stall_cnt,
                         e.v[37], e.v[36], e.v[35:34], e.v[33:32], e.v[31:27], e.v[26:22],
                         e.v[21:17], e.v[16], e.v[15:0]);
            end
        end
    end

    initial begin
        drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        tick(); drv(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("reset_state",  0, 0, 2'b00, 2'b00,  0,  0,  0, 0, 0);

        // Load $5, then an add reading $5 through rs
        tick(); lw(5, 1);            expect_out("A_lw5_issue",  0, 0, 2'b00, 2'b00,  0,  0,  0, 0, 0);
        tick(); add(6, 5, 2, 0);     expect_out("A_stall",      1, 0, 2'b00, 2'b00,  5,  0,  0, 0, 0);
        tick(); add(6, 5, 2, 0);     expect_out("A_bubble",     0, 0, 2'b00, 2'b00,  0,  5,  0, 0, 1);
        tick(); nop();               expect_out("A_fwd_a_wb",   0, 0, 2'b10, 2'b00,  6,  0,  5, 1, 1);

        // Add writing $3, then a sub reading $3 through rt
        tick(); add(3, 1, 2, 0);     expect_out("B_issue",      0, 0, 2'b00, 2'b00,  0,  6,  0, 0, 1);
        tick(); add(4, 8, 3, 0);     expect_out("B_no_stall",   0, 0, 2'b00, 2'b00,  3,  0,  6, 1, 1);
        tick(); nop();               expect_out("B_fwd_b_mem",  0, 0, 2'b00, 2'b01,  4,  3,  0, 0, 1);

        // Two writes to $7 back to back; the younger one must win
        tick(); add(7, 1, 2, 0);     expect_out("C_w1",         0, 0, 2'b00, 2'b00,  0,  4,  3, 1, 1);
        tick(); add(7, 3, 4, 0);     expect_out("C_w2",         0, 0, 2'b00, 2'b00,  7,  0,  4, 1, 1);
        tick(); add(9, 7, 7, 0);     expect_out("C_read",       0, 0, 2'b00, 2'b00,  7,  7,  0, 0, 1);
        tick(); nop();               expect_out("C_mem_wins",   0, 0, 2'b01, 2'b01,  9,  7,  7, 1, 1);

        // Load into $0, then a read of $0
        tick(); lw(0, 1);            expect_out("D_lw0",        0, 0, 2'b00, 2'b00,  0,  9,  7, 1, 1);
        tick(); add(10, 0, 0, 0);    expect_out("D_no_stall",   0, 0, 2'b00, 2'b00,  0,  0,  9, 1, 1);
        tick(); nop();               expect_out("D_no_fwd",     0, 0, 2'b00, 2'b00, 10,  0,  0, 0, 1);
        tick(); nop();               expect_out("D_drain",      0, 0, 2'b00, 2'b00,  0, 10,  0, 1, 1);

        // Load-use hazard together with a taken branch
        tick(); lw(5, 2);            expect_out("E_lw5",        0, 0, 2'b00, 2'b00,  0,  0, 10, 1, 1);
        tick(); add(6, 5, 5, 1);     expect_out("E_flush",      0, 1, 2'b00, 2'b00,  5,  0,  0, 0, 1);
        tick(); nop();               expect_out("E_ex_bubble",  0, 0, 2'b00, 2'b00,  0,  5,  0, 0, 1);

        // An invalid decode slot never stalls, even with matching fields
        tick(); lw(5, 1);            expect_out("F_lw5",        0, 0, 2'b00, 2'b00,  0,  0,  5, 1, 1);
        tick(); drv(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                                     expect_out("F_inv_nostall",0, 0, 2'b00, 2'b00,  5,  0,  0, 0, 1);

        // Fill the pipe, then reset with three instructions in flight
        tick(); add(11, 1, 2, 0);    expect_out("G_i1",         0, 0, 2'b00, 2'b00,  0,  5,  0, 0, 1);
        tick(); add(12, 1, 2, 0);    expect_out("G_i2",         0, 0, 2'b00, 2'b00, 11,  0,  5, 1, 1);
        tick(); add(13, 1, 2, 0);    expect_out("G_i3",         0, 0, 2'b00, 2'b00, 12, 11,  0, 0, 1);
        tick(); drv(1'b0, 1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                                     expect_out("G_rst_held",   0, 0, 2'b00, 2'b00,  0,  0,  0, 0, 1);
        tick(); add(14, 1, 2, 0);    expect_out("G_rst_clear",  0, 0, 2'b00, 2'b00,  0,  0,  0, 0, 0);
        tick(); nop();               expect_out("G_new_ex",     0, 0, 2'b00, 2'b00, 14,  0,  0, 0, 0);
        tick(); nop();               expect_out("G_new_mem",    0, 0, 2'b00, 2'b00,  0, 14,  0, 0, 0);
        tick(); nop();               expect_out("G_new_wb",     0, 0, 2'b00, 2'b00,  0,  0, 14, 1, 0);

        // Load-use through rt; forwarding from WB afterwards
        tick(); lw(20, 1);           expect_out("H_lw20",       0, 0, 2'b00, 2'b00,  0,  0,  0, 0, 0);
        tick(); add(21, 2, 20, 0);   expect_out("H_stall_rt",   1, 0, 2'b00, 2'b00, 20,  0,  0, 0, 0);
        tick(); add(21, 2, 20, 0);   expect_out("H_bubble",     0, 0, 2'b00, 2'b00,  0, 20,  0, 0, 1);
        tick(); nop();               expect_out("H_fwd_b_wb",   0, 0, 2'b00, 2'b10, 21,  0, 20, 1, 1);

        // Matching register fields that are not read do not stall
        tick(); lw(22, 1);           expect_out("I_lw22",       0, 0, 2'b00, 2'b00,  0, 21,  0, 0, 1);
        tick(); drv(1'b1, 1'b1, 5'd22, 5'd22, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                                     expect_out("I_unused_src", 0, 0, 2'b00, 2'b00, 22,  0, 21, 1, 1);

        tick(); nop();
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
